// File: rtl/screen_sequencer.sv
// rtl/screen_sequencer.sv - game-flow screen selector with frame-synchronous fade
module screen_sequencer #(
    parameter int HOLD_FRAMES = 180,
    parameter int FADE_DIV    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vs,
    input  logic       start_btn,
    input  logic       win_evt,
    input  logic       lose_evt,
    output logic [1:0] screen_sel,
    output logic [2:0] fade_level,
    output logic       game_run,
    output logic       game_rst
);

    localparam int HW = ($clog2(HOLD_FRAMES + 1) > 8) ? $clog2(HOLD_FRAMES + 1) : 8;
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_FRAMES);
    localparam logic [7:0]    DIV_LAST = 8'(FADE_DIV - 1);

    localparam logic [1:0] SCR_TITLE = 2'd0;
    localparam logic [1:0] SCR_PLAY  = 2'd1;
    localparam logic [1:0] SCR_WIN   = 2'd2;
    localparam logic [1:0] SCR_LOSE  = 2'd3;

    typedef enum logic [2:0] {
        S_TITLE,
        S_PLAY,
        S_WIN,
        S_LOSE,
        S_FADE_OUT,
        S_FADE_IN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    target_q, target_d;
    logic [1:0]    sel_q, sel_d;
    logic [2:0]    fade_q, fade_d;
    logic          run_q, run_d;
    logic          grst_q, grst_d;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic vs_s1_q, vs_s2_q, vs_prev_q;
    logic btn_s1_q, btn_s2_q, btn_prev_q;
    logic frame_tick, start_press, step;

    // vs idles high, so its synchronizer resets to 1 to avoid a false tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1_q    <= 1'b1;
            vs_s2_q    <= 1'b1;
            vs_prev_q  <= 1'b1;
            btn_s1_q   <= 1'b0;
            btn_s2_q   <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            vs_s1_q    <= vs;
            vs_s2_q    <= vs_s1_q;
            vs_prev_q  <= vs_s2_q;
            btn_s1_q   <= start_btn;
            btn_s2_q   <= btn_s1_q;
            btn_prev_q <= btn_s2_q;
        end
    end

    assign frame_tick  = vs_prev_q & ~vs_s2_q;
    assign start_press = btn_s2_q & ~btn_prev_q;
    assign step        = frame_tick && (div_cnt_q == DIV_LAST);

    function automatic state_t steady_of(input logic [1:0] scr);
        case (scr)
            SCR_PLAY: steady_of = S_PLAY;
            SCR_WIN:  steady_of = S_WIN;
            SCR_LOSE: steady_of = S_LOSE;
            default:  steady_of = S_TITLE;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        sel_d      = sel_q;
        fade_d     = fade_q;
        run_d      = run_q;
        grst_d     = 1'b0;
        div_cnt_d  = 8'd0;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            S_TITLE: begin
                if (start_press) begin
                    state_d  = S_FADE_OUT;
                    target_d = SCR_PLAY;
                end
            end
            S_PLAY: begin
                if (win_evt) begin
                    state_d  = S_FADE_OUT;
                    target_d = SCR_WIN;
                    run_d    = 1'b0;
                end else if (lose_evt) begin
                    state_d  = S_FADE_OUT;
                    target_d = SCR_LOSE;
                    run_d    = 1'b0;
                end
            end
            S_WIN, S_LOSE: begin
                if (frame_tick && (hold_cnt_q < HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (start_press && (hold_cnt_q >= HOLD_MAX)) begin
                    state_d  = S_FADE_OUT;
                    target_d = SCR_TITLE;
                end
            end
            S_FADE_OUT: begin
                div_cnt_d = div_cnt_q;
                if (frame_tick) begin
                    div_cnt_d = step ? 8'd0 : div_cnt_q + 8'd1;
                end
                // The mux switches only on the extra step spent at black.
                if (step) begin
                    if (fade_q != 3'd0) begin
                        fade_d = fade_q - 3'd1;
                    end else begin
                        sel_d     = target_q;
                        grst_d    = (target_q == SCR_PLAY);
                        state_d   = S_FADE_IN;
                        div_cnt_d = 8'd0;
                    end
                end
            end
            S_FADE_IN: begin
                div_cnt_d = div_cnt_q;
                if (frame_tick) begin
                    div_cnt_d = step ? 8'd0 : div_cnt_q + 8'd1;
                end
                if (step) begin
                    fade_d = fade_q + 3'd1;
                    if (fade_q == 3'd6) begin
                        state_d    = steady_of(target_q);
                        run_d      = (target_q == SCR_PLAY);
                        hold_cnt_d = '0;
                        div_cnt_d  = 8'd0;
                    end
                end
            end
            default: begin
                state_d = S_TITLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_TITLE;
            target_q   <= SCR_TITLE;
            sel_q      <= SCR_TITLE;
            fade_q     <= 3'd7;
            run_q      <= 1'b0;
            grst_q     <= 1'b0;
            div_cnt_q  <= 8'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            sel_q      <= sel_d;
            fade_q     <= fade_d;
            run_q      <= run_d;
            grst_q     <= grst_d;
            div_cnt_q  <= div_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign screen_sel = sel_q;
    assign fade_level = fade_q;
    assign game_run   = run_q;
    assign game_rst   = grst_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// tb/tb_screen_sequencer.sv - directed self-checking bench for screen_sequencer
module tb_screen_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vs;
    logic       start_btn;
    logic       win_evt;
    logic       lose_evt;
    logic [1:0] screen_sel;
    logic [2:0] fade_level;
    logic       game_run;
    logic       game_rst;

    int vectors = 0;
    int miscompares = 0;

    logic [2:0] s_lvl;
    logic [1:0] s_sel;
    logic       s_run, s_rst, s_rst_nx;

    screen_sequencer #(.HOLD_FRAMES(3), .FADE_DIV(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs        (vs),
        .start_btn (start_btn),
        .win_evt   (win_evt),
        .lose_evt  (lose_evt),
        .screen_sel(screen_sel),
        .fade_level(fade_level),
        .game_run  (game_run),
        .game_rst  (game_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One vs falling edge; snapshots taken just after the edge that consumes the tick.
    task automatic do_tick();
        vs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        s_lvl = fade_level;
        s_sel = screen_sel;
        s_run = game_run;
        s_rst = game_rst;
        @(posedge clk);
        #1;
        s_rst_nx = game_rst;
        vs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic press();
        start_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fade_run(input logic [1:0] target, input logic [1:0] prev_sel,
                            input int stop_at, input bit inj_press);
        logic [2:0] exp_lvl;
        for (int i = 1; i <= 15; i++) begin
            do_tick();
            exp_lvl = (i <= 7) ? 3'(7 - i) : ((i == 8) ? 3'd0 : 3'(i - 8));
            chk($sformatf("lvl_t%0d", i), 8'(s_lvl), 8'(exp_lvl));
            if (i == 7) chk("sel_before_black", 8'(s_sel), 8'(prev_sel));
            if (i == 8) begin
                chk("sel_at_black", 8'(s_sel), 8'(target));
                chk("game_rst_pulse", 8'(s_rst), 8'(target == 2'd1));
                chk("game_rst_one_cycle", 8'(s_rst_nx), 8'd0);
            end
            if (i == 14) chk("run_before_end", 8'(s_run), 8'd0);
            if (i == 15) chk("run_at_end", 8'(s_run), 8'(target == 2'd1));
            if (i == 3 && inj_press) press();
            if (i == stop_at) break;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vs = 1'b1;
        start_btn = 1'b0;
        win_evt = 1'b0;
        lose_evt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sel", 8'(screen_sel), 8'd0);
        chk("rst_lvl", 8'(fade_level), 8'd7);
        chk("rst_run", 8'(game_run), 8'd0);
        chk("rst_grst", 8'(game_rst), 8'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // win_evt outside PLAY does nothing
        win_evt = 1'b1;
        @(posedge clk);
        #1;
        win_evt = 1'b0;
        do_tick();
        chk("title_win_evt_lvl", 8'(fade_level), 8'd7);
        chk("title_win_evt_sel", 8'(screen_sel), 8'd0);

        // Title -> Play, with a press during the fade that must be ignored
        press();
        chk("press_no_immediate_lvl", 8'(fade_level), 8'd7);
        fade_run(2'd1, 2'd0, 15, 1'b1);
        chk("play_sel", 8'(screen_sel), 8'd1);

        // win and lose together: win wins, run drops on that edge
        win_evt = 1'b1;
        lose_evt = 1'b1;
        @(posedge clk);
        #1;
        win_evt = 1'b0;
        lose_evt = 1'b0;
        chk("run_drop_on_evt", 8'(game_run), 8'd0);
        fade_run(2'd2, 2'd1, 15, 1'b0);
        chk("win_sel", 8'(screen_sel), 8'd2);

        // hold gating: press after 2 ticks ignored, accepted after 3
        do_tick();
        do_tick();
        press();
        do_tick();
        chk("early_press_ignored_lvl", 8'(s_lvl), 8'd7);
        chk("early_press_ignored_sel", 8'(s_sel), 8'd2);

        // held button: single transition back to TITLE only
        start_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fade_run(2'd0, 2'd2, 15, 1'b0);
        do_tick();
        do_tick();
        chk("held_btn_lvl", 8'(fade_level), 8'd7);
        chk("held_btn_sel", 8'(screen_sel), 8'd0);
        start_btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Play again, then lose alone
        press();
        fade_run(2'd1, 2'd0, 15, 1'b0);
        lose_evt = 1'b1;
        @(posedge clk);
        #1;
        lose_evt = 1'b0;
        chk("lose_run_drop", 8'(game_run), 8'd0);
        fade_run(2'd3, 2'd1, 15, 1'b0);
        chk("lose_sel", 8'(screen_sel), 8'd3);

        do_tick();
        do_tick();
        do_tick();
        press();
        fade_run(2'd0, 2'd3, 15, 1'b0);

        // reset during fade-in toward PLAY at level 3
        press();
        fade_run(2'd1, 2'd0, 11, 1'b0);
        chk("pre_reset_lvl", 8'(fade_level), 8'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 8'(screen_sel), 8'd0);
        chk("async_rst_lvl", 8'(fade_level), 8'd7);
        chk("async_rst_run", 8'(game_run), 8'd0);
        chk("async_rst_grst", 8'(game_rst), 8'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_tick();
        do_tick();
        chk("post_rst_sel", 8'(screen_sel), 8'd0);
        chk("post_rst_lvl", 8'(fade_level), 8'd7);
        chk("post_rst_run", 8'(game_run), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
